// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks NUM_DIGITS BCD digits through one
// shared decoder, capturing the input value once per frame and blanking leading zeros.
module seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLANK_LZ    = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    i_en,
   input  logic [4*NUM_DIGITS-1:0] i_digits,
   input  logic [NUM_DIGITS-1:0]   i_dp_mask,
   output logic [3:0]              o_bin_data,
   output logic                    o_dp,
   output logic [NUM_DIGITS-1:0]   o_digit_sel,
   output logic                    o_blank,
   output logic                    o_scan_tick
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = $clog2(NUM_DIGITS);

   logic [CW-1:0]           div_cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic                    redisplay;

   logic                    terminal;
   logic                    wrap;
   logic [IW-1:0]           nidx;
   logic [IW-1:0]           show_idx;
   logic [4*NUM_DIGITS-1:0] src_digits;
   logic [NUM_DIGITS-1:0]   src_dp;
   logic [NUM_DIGITS-1:0]   lz;
   logic                    zero_above;
   logic                    dec_blank;
   logic [3:0]              dec_bin;
   logic                    dec_dp;
   logic [NUM_DIGITS-1:0]   dec_sel;

   always_comb begin
      terminal   = (div_cnt == CW'(REFRESH_DIV - 1));
      nidx       = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      wrap       = terminal && (nidx == '0);
      show_idx   = terminal ? nidx : idx;
      // The digit 0 decode on a wrap must see the value being captured this edge.
      src_digits = wrap ? i_digits  : shadow;
      src_dp     = wrap ? i_dp_mask : shadow_dp;

      lz         = '0;
      zero_above = 1'b1;
      for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
         zero_above = zero_above && (src_digits[4*(k-1) +: 4] == 4'd0);
         lz[k-1]    = zero_above;
      end

      dec_blank = (BLANK_LZ != 0) && (show_idx != '0) && lz[show_idx] && !src_dp[show_idx];
      dec_bin   = '0;
      dec_dp    = 1'b0;
      dec_sel   = '1;
      if (!dec_blank) begin
         dec_bin           = src_digits[{show_idx, 2'b00} +: 4];
         dec_dp            = src_dp[show_idx];
         dec_sel[show_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         div_cnt     <= '0;
         idx         <= '0;
         shadow      <= '0;
         shadow_dp   <= '0;
         redisplay   <= 1'b0;
         o_bin_data  <= '0;
         o_dp        <= 1'b0;
         o_digit_sel <= '1;
         o_blank     <= 1'b1;
         o_scan_tick <= 1'b0;
      end else if (!i_en) begin
         redisplay   <= 1'b1;
         o_digit_sel <= '1;
         o_blank     <= 1'b1;
         o_scan_tick <= 1'b0;
      end else begin
         redisplay   <= 1'b0;
         o_scan_tick <= terminal;
         if (terminal) begin
            div_cnt <= '0;
            idx     <= nidx;
            if (wrap) begin
               shadow    <= i_digits;
               shadow_dp <= i_dp_mask;
            end
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end
         // Outputs otherwise hold; they reload on an advance or after a disabled spell.
         if (terminal || redisplay) begin
            o_bin_data  <= dec_bin;
            o_dp        <= dec_dp;
            o_digit_sel <= dec_sel;
            o_blank     <= dec_blank;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, checked against a
// model that tracks enabled-edge count and derives digit position arithmetically.
module tb_seg_scan_ctrl;

   localparam int N   = 4;
   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        i_en = 1'b1;
   logic [15:0] i_digits = '0;
   logic [3:0]  i_dp_mask = '0;

   logic [3:0] bin_a, sel_a, bin_b, sel_b;
   logic       dp_a, blank_a, tick_a, dp_b, blank_b, tick_b;

   seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_LZ(1)) dut_a (
      .clk(clk), .rstn(rstn), .i_en(i_en), .i_digits(i_digits), .i_dp_mask(i_dp_mask),
      .o_bin_data(bin_a), .o_dp(dp_a), .o_digit_sel(sel_a), .o_blank(blank_a),
      .o_scan_tick(tick_a));

   seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_LZ(0)) dut_b (
      .clk(clk), .rstn(rstn), .i_en(i_en), .i_digits(i_digits), .i_dp_mask(i_dp_mask),
      .o_bin_data(bin_b), .o_dp(dp_b), .o_digit_sel(sel_b), .o_blank(blank_b),
      .o_scan_tick(tick_b));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: enabled edges since reset, captured frame, last-edge-was-disabled.
   int          e = 0;
   logic [15:0] sh = '0;
   logic [3:0]  shdp = '0;
   bit          prev_dis = 1'b0;
   logic [3:0]  xbin[2], xsel[2];
   bit          xdp[2], xbl[2];
   bit          xtick = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void decode(input int k, input logic [15:0] d, input logic [3:0] dp,
                                  input bit blz, output logic [3:0] b, output bit p,
                                  output logic [3:0] sel, output bit bl);
      bl = blz && (k > 0) && ((d >> (4*k)) == 16'd0) && !dp[k];
      if (bl) begin
         b = 4'd0; p = 1'b0; sel = 4'hF;
      end else begin
         b = 4'((d >> (4*k)) & 16'hF); p = dp[k]; sel = ~(4'b0001 << k);
      end
   endfunction

   task automatic step();
      logic        r, en;
      logic [15:0] d;
      logic [3:0]  m;
      logic [3:0]  gb[2], gs[2];
      logic        gd[2], gl[2];
      r = rstn; en = i_en; d = i_digits; m = i_dp_mask;
      @(posedge clk);
      if (r) begin
         e = 0; sh = '0; shdp = '0; prev_dis = 1'b0; xtick = 1'b0;
         for (int i = 0; i < 2; i++) begin
            xbin[i] = 4'd0; xdp[i] = 1'b0; xsel[i] = 4'hF; xbl[i] = 1'b1;
         end
      end else if (!en) begin
         prev_dis = 1'b1; xtick = 1'b0;
         for (int i = 0; i < 2; i++) begin
            xsel[i] = 4'hF; xbl[i] = 1'b1;
         end
      end else begin
         e++;
         xtick = (e % DIV) == 0;
         if (xtick && (e % (DIV*N)) == 0) begin
            sh = d; shdp = m;
         end
         if (xtick || prev_dis)
            for (int i = 0; i < 2; i++)
               decode((e / DIV) % N, sh, shdp, (i == 0), xbin[i], xdp[i], xsel[i], xbl[i]);
         prev_dis = 1'b0;
      end
      #1;
      gb[0] = bin_a; gs[0] = sel_a; gd[0] = dp_a; gl[0] = blank_a;
      gb[1] = bin_b; gs[1] = sel_b; gd[1] = dp_b; gl[1] = blank_b;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("sel%0d", i),   32'(gs[i]), 32'(xsel[i]));
         check($sformatf("blank%0d", i), 32'(gl[i]), 32'(xbl[i]));
         check($sformatf("bin%0d", i),   32'(gb[i]), 32'(xbin[i]));
         check($sformatf("dp%0d", i),    32'(gd[i]), 32'(xdp[i]));
         check($sformatf("onehot%0d", i), 32'($countones(~gs[i]) <= 1), 32'd1);
      end
      check("tick_a", 32'(tick_a), 32'(xtick));
      check("tick_b", 32'(tick_b), 32'(xtick));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until the model sits at digit position p with p_cnt cycles elapsed in it.
   task automatic wait_pos(input int p, input int p_cnt);
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         if (((e / DIV) % N) == p && (e % DIV) == p_cnt && !prev_dis) ok = 1'b1;
         else step();
      end
      check("wait_pos", 32'(ok), 32'd1);
   endtask

   initial begin
      int hold;
      // Reset held, then released with enable high.
      i_digits = 16'($urandom);
      rstn = 1'b1; i_en = 1'b1;
      run(3);
      rstn = 1'b0;
      i_digits = 16'h1234; i_dp_mask = 4'b0000;
      run(2 * N * DIV + 2);

      // Leading-zero blanking, then a dp request on a zero digit.
      i_digits = 16'h0070;
      run(2 * N * DIV);
      i_dp_mask = 4'b0100;
      run(2 * N * DIV);
      i_dp_mask = 4'b0000;

      // Mid-frame change must wait for the next wrap.
      i_digits = 16'h1234;
      run(N * DIV);
      wait_pos(1, 0);
      i_digits = 16'h5678;
      run(2 * N * DIV);

      // Enable gating mid-digit.
      wait_pos(3, 1);
      i_en = 1'b0;
      run(10);
      i_en = 1'b1;
      run(N * DIV + 3);

      // Reset for one cycle mid-frame.
      wait_pos(2, 2);
      rstn = 1'b1;
      run(1);
      rstn = 1'b0;
      run(N * DIV + 2);

      // Random traffic with occasional disables and resets.
      hold = 0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 7) == 0)
            i_digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
         if ($urandom_range(0, 9) == 0)
            i_dp_mask = 4'($urandom) & 4'($urandom);
         if (i_en && $urandom_range(0, 15) == 0) i_en = 1'b0;
         else if (!i_en && $urandom_range(0, 2) == 0) i_en = 1'b1;
         rstn = ($urandom_range(0, 99) == 0);
         step();
         hold++;
      end
      rstn = 1'b0; i_en = 1'b1;
      run(N * DIV);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
